// File: rtl/fetch_pc_unit_if.sv
// Bus bundle for the fetch PC unit: redirect input, instruction-memory
// request/response channels, decode-side output queue and debug state.
//
// Handshake rules (all channels): a transfer happens on a rising clock edge
// where both valid and ready are high. The request side holds valid and addr
// stable until accepted (unless redirected); the response channel has no
// ready and delivers exactly one beat per accepted request, at least one cycle
// later; the decode side pops the head whenever out_valid && out_ready.
interface fetch_pc_unit_if #(
  parameter int XLEN = 64,
  parameter int ILEN = 32
);
  logic            redirect_valid;
  logic [XLEN-1:0] redirect_pc;
  logic            imem_req_valid;
  logic            imem_req_ready;
  logic [XLEN-1:0] imem_req_addr;
  logic            imem_resp_valid;
  logic [ILEN-1:0] imem_resp_data;
  logic            out_valid;
  logic            out_ready;
  logic [ILEN-1:0] out_instr;
  logic [XLEN-1:0] out_pc;
  logic [XLEN-1:0] out_npc;
  logic            fetch_busy;
  // FSM state for checkers: 0 IDLE, 1 REQ, 2 WAIT, 3 DROP
  logic [1:0]      fsm_state;

  // Fetch unit side
  modport master (
    input  redirect_valid, redirect_pc, imem_req_ready, imem_resp_valid,
           imem_resp_data, out_ready,
    output imem_req_valid, imem_req_addr, out_valid, out_instr, out_pc,
           out_npc, fetch_busy, fsm_state
  );

  // Environment side (memory, execute, decode)
  modport slave (
    output redirect_valid, redirect_pc, imem_req_ready, imem_resp_valid,
           imem_resp_data, out_ready,
    input  imem_req_valid, imem_req_addr, out_valid, out_instr, out_pc,
           out_npc, fetch_busy, fsm_state
  );
endinterface

// File: rtl/fetch_pc_unit.sv
// Instruction-fetch front end: holds the fetch PC, issues one outstanding
// read at a time to instruction memory, and queues returned words tagged
// with PC / next-PC for decode. A redirect reloads the PC, flushes the queue
// and discards whatever response is still in flight.
module fetch_pc_unit #(
  parameter int              XLEN        = 64,
  parameter int              INSTR_BYTES = 4,
  parameter int              ILEN        = 32,
  parameter logic [XLEN-1:0] RESET_PC    = 64'h0,
  parameter int              FIFO_DEPTH  = 4
) (
  input logic             clk,
  input logic             reset,
  fetch_pc_unit_if.master bus
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0]   DEPTH_C = CW'(FIFO_DEPTH);
  localparam logic [XLEN-1:0] INC     = XLEN'(INSTR_BYTES);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    DROP = 2'd3
  } state_t;

  state_t          state;
  logic [XLEN-1:0] fetch_pc;
  logic [XLEN-1:0] req_pc_q;

  logic [PW-1:0]   wr_ptr;
  logic [PW-1:0]   rd_ptr;
  logic [CW-1:0]   count;
  logic [CW-1:0]   count_next;

  logic [ILEN-1:0] instr_mem [FIFO_DEPTH];
  logic [XLEN-1:0] pc_mem    [FIFO_DEPTH];
  logic [XLEN-1:0] npc_mem   [FIFO_DEPTH];

  logic            not_empty;
  logic            push;
  logic            pop;

  // A redirect kills any same-cycle push or pop: the queue is flushed anyway
  assign not_empty = (count != '0);
  assign push      = (state == WAIT) && bus.imem_resp_valid && !bus.redirect_valid;
  assign pop       = not_empty && bus.out_ready && !bus.redirect_valid;

  // Occupancy after this edge; WAIT uses it to decide whether to fetch again
  always_comb begin
    count_next = count;
    if (push && !pop) begin
      count_next = count + CW'(1);
    end else if (pop && !push) begin
      count_next = count - CW'(1);
    end
  end

  // Fetch FSM and PC; redirect overrides every other transition
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      fetch_pc <= RESET_PC;
      req_pc_q <= '0;
    end else if (bus.redirect_valid) begin
      // PC is not incremented even if a request is accepted this cycle
      fetch_pc <= bus.redirect_pc;
      case (state)
        IDLE:    state <= REQ;
        REQ:     state <= bus.imem_req_ready ? DROP : REQ;
        WAIT:    state <= bus.imem_resp_valid ? REQ : DROP;
        DROP:    state <= bus.imem_resp_valid ? REQ : DROP;
        default: state <= IDLE;
      endcase
    end else begin
      case (state)
        IDLE: begin
          if (count < DEPTH_C) begin
            state <= REQ;
          end
        end
        REQ: begin
          if (bus.imem_req_ready) begin
            req_pc_q <= fetch_pc;
            fetch_pc <= fetch_pc + INC;
            state    <= WAIT;
          end
        end
        WAIT: begin
          if (bus.imem_resp_valid) begin
            state <= (count_next < DEPTH_C) ? REQ : IDLE;
          end
        end
        DROP: begin
          if (bus.imem_resp_valid) begin
            state <= REQ;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Queue pointers and occupancy; redirect empties the queue
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (bus.redirect_valid) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
      count <= count_next;
    end
  end

  // Queue storage; contents are only visible through the head mux below
  always_ff @(posedge clk) begin
    if (push) begin
      instr_mem[wr_ptr] <= bus.imem_resp_data;
      pc_mem[wr_ptr]    <= req_pc_q;
      npc_mem[wr_ptr]   <= req_pc_q + INC;
    end
  end

  assign bus.imem_req_valid = (state == REQ);
  assign bus.imem_req_addr  = fetch_pc;
  assign bus.fetch_busy     = (state == WAIT) || (state == DROP);
  assign bus.fsm_state      = state;

  assign bus.out_valid = not_empty;
  assign bus.out_instr = not_empty ? instr_mem[rd_ptr] : '0;
  assign bus.out_pc    = not_empty ? pc_mem[rd_ptr]    : '0;
  assign bus.out_npc   = not_empty ? npc_mem[rd_ptr]   : '0;

endmodule

// File: tb/tb_fetch_pc_unit.sv
// Bench for fetch_pc_unit: a memory model answering each accepted request
// after a random delay, random decode backpressure and redirects, and a
// transaction-level scoreboard of the PCs that must reach decode.
module tb_fetch_pc_unit;

  localparam int              XLEN        = 64;
  localparam int              ILEN        = 32;
  localparam int              INSTR_BYTES = 4;
  localparam int              FIFO_DEPTH  = 4;
  localparam logic [XLEN-1:0] RESET_PC    = 64'h0;
  localparam logic [63:0]     NONE        = 64'hDEAD_BEEF_DEAD_BEEF;

  // ---------------- clock / reset ----------------
  logic clk   = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  fetch_pc_unit_if #(.XLEN(XLEN), .ILEN(ILEN)) bus ();

  fetch_pc_unit #(
    .XLEN(XLEN), .INSTR_BYTES(INSTR_BYTES), .ILEN(ILEN),
    .RESET_PC(RESET_PC), .FIFO_DEPTH(FIFO_DEPTH)
  ) dut (
    .clk(clk), .reset(reset), .bus(bus.master)
  );

  // ---------------- counters / checking ----------------
  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Memory contents: a fixed scramble of the address
  function automatic logic [31:0] mem_word(input logic [63:0] a);
    return a[31:0] ^ {a[47:32], a[63:48]} ^ 32'h9E37_79B9;
  endfunction

  function automatic logic [63:0] at(input logic [63:0] q[$], input int i);
    if (i < q.size()) return q[i];
    return NONE;
  endfunction

  // ---------------- knobs ----------------
  int          rdy_pct   = 100;
  int          ordy_pct  = 100;
  int          redir_pct = 0;
  int          dly_min   = 1;
  int          dly_max   = 1;
  int          arm_mode  = 0;   // 0 random, 1 now, 2 in WAIT on arm_addr, 3 on handshake of arm_addr
  logic [63:0] arm_addr  = '0;
  logic [63:0] arm_target = '0;
  int          fired     = 0;

  // ---------------- reference model / scoreboard ----------------
  logic        pending = 1'b0;
  logic        stale   = 1'b0;
  logic [63:0] pend_addr = '0;
  int          pend_timer = 0;
  logic [63:0] next_req_addr = RESET_PC;
  logic [63:0] exp_q[$];
  logic [63:0] req_log[$];
  logic [63:0] pop_pc_log[$];
  logic [63:0] pop_npc_log[$];
  logic [63:0] pop_instr_log[$];
  int          total_pops = 0;

  logic        smp_req_valid, smp_out_valid, smp_busy;
  logic [1:0]  smp_state;

  function automatic logic [63:0] rand_target();
    logic [63:0] t;
    t = {$urandom, $urandom};
    if ($urandom_range(0, 3) == 0) t = 64'hFFFF_FFFF_FFFF_FFF0 + 64'($urandom_range(0, 3) * 4);
    else if ($urandom_range(0, 3) != 0) t[1:0] = 2'b00;
    return t;
  endfunction

  // ---------------- driver: one clock cycle ----------------
  task automatic step();
    logic        s_req_valid, s_out_valid, s_busy;
    logic [63:0] s_addr, s_pc, s_npc, s_instr, tgt, e;
    logic        rdy, ordy, resp, redir, hs, pop;
    @(negedge clk);
    s_req_valid = bus.imem_req_valid;
    s_addr      = bus.imem_req_addr;
    s_out_valid = bus.out_valid;
    s_pc        = bus.out_pc;
    s_npc       = bus.out_npc;
    s_instr     = 64'(bus.out_instr);
    s_busy      = bus.fetch_busy;
    smp_req_valid = s_req_valid;
    smp_out_valid = s_out_valid;
    smp_busy      = s_busy;
    smp_state     = bus.fsm_state;

    check("fetch_busy", 64'(s_busy), 64'(pending && !stale));
    if (pending && !stale) check("req_while_busy", 64'(s_req_valid), 64'(0));
    if (!s_out_valid) check("empty_head_zero", s_pc | s_npc | s_instr, 64'(0));

    rdy   = !pending && ($urandom_range(0, 99) < rdy_pct);
    ordy  = $urandom_range(0, 99) < ordy_pct;
    resp  = pending && (pend_timer == 0);
    redir = 1'b0;
    tgt   = '0;
    case (arm_mode)
      1: begin redir = 1'b1; tgt = arm_target; arm_mode = 0; fired++; end
      2: if (pending && !stale && pend_addr == arm_addr && !resp) begin
           redir = 1'b1; tgt = arm_target; arm_mode = 0; fired++;
         end
      3: if (s_req_valid && rdy && s_addr == arm_addr) begin
           redir = 1'b1; tgt = arm_target; arm_mode = 0; fired++;
         end
      default: if ($urandom_range(0, 99) < redir_pct) begin
           redir = 1'b1; tgt = rand_target();
         end
    endcase

    bus.imem_req_ready  = rdy;
    bus.out_ready       = ordy;
    bus.imem_resp_valid = resp;
    bus.imem_resp_data  = resp ? mem_word(pend_addr) : $urandom;
    bus.redirect_valid  = redir;
    bus.redirect_pc     = redir ? tgt : {$urandom, $urandom};

    hs  = s_req_valid && rdy;
    pop = s_out_valid && ordy && !redir;

    if (pop) begin
      check("sb_has_entry", 64'(exp_q.size() > 0), 64'(1));
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("out_pc", s_pc, e);
        check("out_npc", s_npc, e + 64'(INSTR_BYTES));
        check("out_instr", s_instr, 64'(mem_word(e)));
      end
      pop_pc_log.push_back(s_pc);
      pop_npc_log.push_back(s_npc);
      pop_instr_log.push_back(s_instr);
      total_pops++;
    end

    if (hs) begin
      check("req_addr", s_addr, next_req_addr);
      req_log.push_back(s_addr);
      if (!redir) exp_q.push_back(s_addr);
      pending    = 1'b1;
      pend_addr  = s_addr;
      pend_timer = int'($urandom_range(dly_min, dly_max)) - 1;
      next_req_addr = s_addr + 64'(INSTR_BYTES);
    end else if (resp) begin
      pending = 1'b0;
      stale   = 1'b0;
    end else if (pending) begin
      pend_timer--;
    end

    if (redir) begin
      exp_q.delete();
      req_log.delete();
      pop_pc_log.delete();
      pop_npc_log.delete();
      pop_instr_log.delete();
      next_req_addr = tgt;
    end
  endtask

  // Asynchronous reset in the middle of a cycle; memory timer is frozen
  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    bus.redirect_valid  = 1'b0;
    bus.imem_resp_valid = 1'b0;
    bus.imem_req_ready  = 1'b0;
    bus.out_ready       = 1'b0;
    #1;
    check("rst_req_valid", 64'(bus.imem_req_valid), 64'(0));
    check("rst_req_addr", bus.imem_req_addr, RESET_PC);
    check("rst_out_valid", 64'(bus.out_valid), 64'(0));
    check("rst_out_fields", bus.out_pc | bus.out_npc | 64'(bus.out_instr), 64'(0));
    check("rst_busy", 64'(bus.fetch_busy), 64'(0));
    exp_q.delete();
    req_log.delete();
    pop_pc_log.delete();
    pop_npc_log.delete();
    pop_instr_log.delete();
    next_req_addr = RESET_PC;
    stale    = pending;
    arm_mode = 0;
    fired    = 0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic run_until_pops(input int n, input int budget, input string tag);
    for (int i = 0; i < budget && pop_pc_log.size() < n; i++) step();
    check(tag, 64'(pop_pc_log.size() >= n), 64'(1));
  endtask

  // ---------------- main sequence ----------------
  initial begin
    bus.redirect_valid  = 1'b0;
    bus.redirect_pc     = '0;
    bus.imem_req_ready  = 1'b0;
    bus.imem_resp_valid = 1'b0;
    bus.imem_resp_data  = '0;
    bus.out_ready       = 1'b0;

    // Streaming with 1-cycle memory, no backpressure
    do_reset();
    rdy_pct = 100; ordy_pct = 100; dly_min = 1; dly_max = 1; redir_pct = 0;
    for (int i = 0; i < 12; i++) step();
    check("t1_first_req", at(req_log, 0), RESET_PC);
    check("t1_pc0", at(pop_pc_log, 0), 64'h0);
    check("t1_pc1", at(pop_pc_log, 1), 64'h4);
    check("t1_pc2", at(pop_pc_log, 2), 64'h8);
    check("t1_npc0", at(pop_npc_log, 0), 64'h4);
    check("t1_npc1", at(pop_npc_log, 1), 64'h8);
    check("t1_npc2", at(pop_npc_log, 2), 64'hC);
    check("t1_instr1", at(pop_instr_log, 1), 64'(mem_word(64'h4)));

    // Decode stalled: queue fills, fetch stops, then drains in order
    do_reset();
    ordy_pct = 0;
    for (int i = 0; i < 20; i++) step();
    check("t2_req_cnt", 64'(req_log.size()), 64'(FIFO_DEPTH));
    check("t2_req3", at(req_log, 3), 64'hC);
    check("t2_idle_no_req", 64'(smp_req_valid), 64'(0));
    check("t2_state_idle", 64'(smp_state), 64'(0));
    ordy_pct = 100;
    run_until_pops(5, 40, "t2_drain_done");
    check("t2_pop0", at(pop_pc_log, 0), 64'h0);
    check("t2_pop3", at(pop_pc_log, 3), 64'hC);
    check("t2_resume", at(req_log, 4), 64'h10);

    // Redirect while waiting on 0x4 with a slow memory
    do_reset();
    dly_min = 3; dly_max = 3;
    arm_mode = 2; arm_addr = 64'h4; arm_target = 64'h8000;
    for (int i = 0; i < 30 && fired == 0; i++) step();
    check("t3_fired", 64'(fired), 64'(1));
    step();
    check("t3_drop_busy", 64'(smp_busy), 64'(1));
    run_until_pops(1, 40, "t3_out_seen");
    check("t3_next_req", at(req_log, 0), 64'h8000);
    check("t3_first_out", at(pop_pc_log, 0), 64'h8000);

    // Redirect coinciding with the handshake for 0x10
    do_reset();
    dly_min = 1; dly_max = 2;
    arm_mode = 3; arm_addr = 64'h10; arm_target = 64'h200;
    for (int i = 0; i < 40 && fired == 0; i++) step();
    check("t4_fired", 64'(fired), 64'(1));
    step();
    check("t4_state_drop", 64'(smp_state), 64'(3));
    run_until_pops(1, 40, "t4_out_seen");
    check("t4_next_req", at(req_log, 0), 64'h200);
    check("t4_first_out", at(pop_pc_log, 0), 64'h200);

    // PC wrap-around
    arm_mode = 1; arm_target = 64'hFFFF_FFFF_FFFF_FFFC;
    step();
    run_until_pops(2, 40, "t5_out_seen");
    check("t5_pc", at(pop_pc_log, 0), 64'hFFFF_FFFF_FFFF_FFFC);
    check("t5_npc", at(pop_npc_log, 0), 64'h0);
    check("t5_wrap_req", at(req_log, 1), 64'h0);
    check("t5_wrap_out", at(pop_pc_log, 1), 64'h0);

    // Reset while a response is in flight; late response must be ignored
    dly_min = 6; dly_max = 6;
    for (int i = 0; i < 20 && !(pending && !stale); i++) step();
    step();
    check("t6_in_wait", 64'(smp_busy), 64'(1));
    do_reset();
    for (int i = 0; i < 30 && pending; i++) step();
    check("t6_stale_delivered", 64'(pending), 64'(0));
    step();
    check("t6_stale_not_pushed", 64'(smp_out_valid), 64'(0));
    dly_min = 1; dly_max = 1;
    run_until_pops(1, 40, "t6_out_seen");
    check("t6_first_req", at(req_log, 0), RESET_PC);
    check("t6_first_out", at(pop_pc_log, 0), RESET_PC);

    // Random traffic with random redirects
    rdy_pct = 70; ordy_pct = 60; dly_min = 1; dly_max = 4; redir_pct = 3;
    total_pops = 0;
    for (int i = 0; i < 3000; i++) step();
    check("rand_progress", 64'(total_pops > 200), 64'(1));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
